rf_wb_sched: RTL
================

Name: rf_wb_sched

Overview:
- Write-back scheduler for the 16x32 register file, which has one write port.
- Shares that write port between the ALU result path and the load-return path. The ALU always has priority; load returns are held in a small FIFO.
- Keeps a 16-bit scoreboard of registers waiting on a load, and raises a decode stall on read-after-load hazards.
- Its registered write outputs drive the register file's wr_en, wr_ad and wr_data directly.

Parameters:
- QDEPTH, 4, load-return FIFO depth; power of two, 2..16.
- QAW, 2, FIFO pointer width; must equal log2(QDEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- alu_wr_en  in  1  ALU result write request this cycle
- alu_wr_ad  in  4  ALU destination register
- alu_wr_data  in  32  ALU result
- ld_issue  in  1  a load to ld_issue_ad has been dispatched
- ld_issue_ad  in  4  destination of the dispatched load
- ld_valid  in  1  load data returning
- ld_ready  out  1  FIFO can accept a load return
- ld_ad  in  4  returning load destination
- ld_data  in  32  returning load data
- rd_addr_a  in  4  decode source A address
- rd_addr_b  in  4  decode source B address
- rd_use_a  in  1  source A is actually read
- rd_use_b  in  1  source B is actually read
- stall  out  1  decode must hold
- rf_wr_en  out  1  register-file write enable (registered)
- rf_wr_ad  out  4  register-file write address (registered)
- rf_wr_data  out  32  register-file write data (registered)
- pending  out  16  scoreboard; bit i = load outstanding to register i
- q_count  out  QAW+1  FIFO occupancy
- waw_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: all state is updated only on the rising edge of clk. While rst_n=0 at an edge:
  - rf_wr_en=0, rf_wr_ad=0, rf_wr_data=0;
  - pending=0, q_count=0, FIFO pointers=0, waw_err=0, load-source flag=0.
  - ld_ready=0 while rst_n is low. No push, pop or scoreboard update happens in a reset cycle, so a transfer in flight is discarded.
- FIFO push:
  - ld_ready = rst_n && (q_count < QDEPTH), combinational.
  - A push happens when ld_valid && ld_ready; the entry is {ld_ad, ld_data}.
  - ld_valid while ld_ready=0: the transfer is not taken, and the requester must hold it.
- Write-port arbitration, evaluated each cycle and registered at the edge:
  - alu_wr_en=1: output register <= {1, alu_wr_ad, alu_wr_data}; src_ld <= 0; no pop.
  - Otherwise, if q_count != 0: pop the head; output register <= {1, head ad, head data}; src_ld <= 1.
  - Otherwise: rf_wr_en <= 0; rf_wr_ad and rf_wr_data hold their values.
- Latency:
  - ALU request to rf_wr_en: 1 cycle.
  - Load accepted to rf_wr_en: at least 2 cycles (push, then pop), more while the ALU occupies the port.
- Simultaneous push and pop: q_count is unchanged. A pop never returns an entry pushed in the same cycle.
- Wrap-around: pointers are QAW bits and wrap modulo QDEPTH. q_count spans 0..QDEPTH.
- Scoreboard:
  - Set: ld_issue sets pending[ld_issue_ad].
  - Clear: pending[rf_wr_ad] is cleared at the edge where rf_wr_en && src_ld, i.e. the same edge that writes the register file.
  - Set and clear of the same bit in one cycle: set wins.
- stall (combinational) = (rd_use_a && pending[rd_addr_a]) || (rd_use_b && pending[rd_addr_b]).
  - Because the scoreboard clears in the write edge, the first cycle with stall=0 reads the updated register.
- waw_err is set, and stays set until reset, on any of:
  - ld_issue to a register already pending (the bit stays 1 and clears at the first load write-back);
  - alu_wr_en to a pending register (the write is still performed);
  - a load write-back (rf_wr_en && src_ld) to a register not pending.

Optional Feature:
- Macro: RF_WB_LD_BYPASS_EN.
- Defined: when ld_valid && ld_ready && !alu_wr_en && q_count==0, the load return goes straight to the output register with src_ld=1 and no push. Load latency is then 1 cycle.
- Undefined: every load return goes through the FIFO (minimum latency 2). All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while driving ld_valid=1 and alu_wr_en=1 -> rf_wr_en=0, pending=0, q_count=0, ld_ready=0, waw_err=0. First cycle after release -> ld_ready=1.
- ALU only: alu_wr_en=1, ad=5, data=0xDEADBEEF -> next cycle rf_wr_en=1, rf_wr_ad=5, rf_wr_data=0xDEADBEEF. A following idle cycle -> rf_wr_en=0.
- Load hazard: ld_issue ad=3, then rd_use_a=1 with rd_addr_a=3 -> stall=1, pending=0x0008. Return ld_ad=3, data=0x12345678 with the ALU idle:
  - without bypass: rf_wr_en 2 cycles later; pending=0 and stall=0 the cycle after that write;
  - with bypass: rf_wr_en after 1 cycle.
- Contention and FIFO full: alu_wr_en=1 for 6 cycles while pushing loads to r1..r4, then a fifth -> q_count reaches 4, ld_ready=0, the fifth is held. After the ALU stops, r1..r4 are written in order on consecutive cycles.
- Wrap-around: 10 back-to-back load returns with the ALU idle -> the write sequence matches push order exactly, and q_count never exceeds 2.
- Errors: ld_issue ad=7 twice -> waw_err=1. waw_err stays 1 through the later traffic until rst_n=0.

Source files
------------

// File: rtl/rf_wb_sched.sv
// rtl/rf_wb_sched.sv - register-file write-back scheduler (ALU priority, load-return FIFO, scoreboard)
// Optional macro RF_WB_LD_BYPASS_EN: a load return skips the empty FIFO when the ALU is idle.
module rf_wb_sched #(
  parameter int QDEPTH = 4,
  parameter int QAW    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           alu_wr_en,
  input  logic [3:0]     alu_wr_ad,
  input  logic [31:0]    alu_wr_data,
  input  logic           ld_issue,
  input  logic [3:0]     ld_issue_ad,
  input  logic           ld_valid,
  output logic           ld_ready,
  input  logic [3:0]     ld_ad,
  input  logic [31:0]    ld_data,
  input  logic [3:0]     rd_addr_a,
  input  logic [3:0]     rd_addr_b,
  input  logic           rd_use_a,
  input  logic           rd_use_b,
  output logic           stall,
  output logic           rf_wr_en,
  output logic [3:0]     rf_wr_ad,
  output logic [31:0]    rf_wr_data,
  output logic [15:0]    pending,
  output logic [QAW:0]   q_count,
  output logic           waw_err
);

  localparam logic [QAW:0] QDEPTH_C = (QAW+1)'(QDEPTH);

  logic [35:0]    mem_q [QDEPTH];
  logic [QAW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QAW:0]   cnt_q, cnt_d;
  logic           rf_wr_en_q, rf_wr_en_d;
  logic [3:0]     rf_wr_ad_q, rf_wr_ad_d;
  logic [31:0]    rf_wr_data_q, rf_wr_data_d;
  logic           src_ld_q, src_ld_d;
  logic [15:0]    pending_q, pending_d;
  logic           waw_q, waw_d;
  logic           push, pop, bypass;
  logic           ld_wb;

  assign ld_ready = rst_n && (cnt_q < QDEPTH_C);

`ifdef RF_WB_LD_BYPASS_EN
  assign bypass = ld_valid && ld_ready && !alu_wr_en && (cnt_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push  = ld_valid && ld_ready && !bypass;
  assign pop   = !alu_wr_en && (cnt_q != '0);
  assign ld_wb = rf_wr_en_q && src_ld_q;

  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_wr_ad_d   = rf_wr_ad_q;
    rf_wr_data_d = rf_wr_data_q;
    src_ld_d     = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;

    if (alu_wr_en) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_ad_d   = alu_wr_ad;
      rf_wr_data_d = alu_wr_data;
    end else if (bypass) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_ad_d   = ld_ad;
      rf_wr_data_d = ld_data;
      src_ld_d     = 1'b1;
    end else if (pop) begin
      rf_wr_en_d   = 1'b1;
      {rf_wr_ad_d, rf_wr_data_d} = mem_q[rd_ptr_q];
      src_ld_d     = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + QAW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + QAW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (QAW+1)'(1);
      2'b01:   cnt_d = cnt_q - (QAW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    // Clear first so that a same-cycle issue to the retiring register wins.
    pending_d = pending_q;
    if (ld_wb)    pending_d[rf_wr_ad_q]  = 1'b0;
    if (ld_issue) pending_d[ld_issue_ad] = 1'b1;

    waw_d = waw_q;
    if (ld_issue && pending_q[ld_issue_ad]) waw_d = 1'b1;
    if (alu_wr_en && pending_q[alu_wr_ad])  waw_d = 1'b1;
    if (ld_wb && !pending_q[rf_wr_ad_q])    waw_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_ad_q   <= '0;
      rf_wr_data_q <= '0;
      src_ld_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      pending_q    <= '0;
      waw_q        <= 1'b0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_ad_q   <= rf_wr_ad_d;
      rf_wr_data_q <= rf_wr_data_d;
      src_ld_q     <= src_ld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      waw_q        <= waw_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ld_ad, ld_data};
  end

  assign stall      = (rd_use_a && pending_q[rd_addr_a]) || (rd_use_b && pending_q[rd_addr_b]);
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_ad   = rf_wr_ad_q;
  assign rf_wr_data = rf_wr_data_q;
  assign pending    = pending_q;
  assign q_count    = cnt_q;
  assign waw_err    = waw_q;

endmodule
